// File: rtl/if_id_elastic.sv
// Elastic IF/ID pipeline register: a main entry driving decode plus one skid entry,
// so up_ready_o depends only on registered state. Adds flush, start gating and perf counters.
module if_id_elastic #(
    parameter int                  INST_W      = 32,
    parameter int                  PC_W        = 32,
    parameter int                  CNT_W       = 16,
    parameter logic [INST_W-1:0]   BUBBLE_INST = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [INST_W-1:0] inst_i,
    input  logic [PC_W-1:0]   PC_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [PC_W-1:0]   PC_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [INST_W-1:0]   main_inst, skid_inst;
    logic [PC_W-1:0]     main_pc, skid_pc;
    logic [CNT_W-1:0]    stall_cnt, flush_cnt;

    logic up_fire, dn_fire;
    logic ld_main_in, ld_main_skid, ld_skid, to_bubble;
    logic stall_inc, flush_inc;

    // rst_i keeps up_ready_o low while reset is held, even though EMPTY would allow it.
    assign up_ready_o = rst_i & start_i & (state != TWO);
    assign dn_valid_o = start_i & (state != EMPTY);
    assign up_fire    = up_valid_i & up_ready_o;
    assign dn_fire    = dn_valid_o & dn_ready_i;

    assign stall_inc  = dn_valid_o & ~dn_ready_i;
    assign flush_inc  = start_i & flush_i;

    assign inst_o      = main_inst;
    assign PC_o        = main_pc;
    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt    = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        to_bubble    = 1'b0;
        if (start_i) begin
            if (flush_i) begin
                state_nxt = EMPTY;
                to_bubble = 1'b1;
            end else begin
                unique case (state)
                    EMPTY: if (up_fire) begin
                        ld_main_in = 1'b1;
                        state_nxt  = ONE;
                    end
                    ONE: if (up_fire && dn_fire) begin
                        ld_main_in = 1'b1;
                    end else if (up_fire) begin
                        ld_skid   = 1'b1;
                        state_nxt = TWO;
                    end else if (dn_fire) begin
                        to_bubble = 1'b1;
                        state_nxt = EMPTY;
                    end
                    TWO: if (dn_fire) begin
                        ld_main_skid = 1'b1;
                        state_nxt    = ONE;
                    end
                    default: state_nxt = EMPTY;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the two entries are plain registers, so resetting them is cheap and keeps X out of PC_o.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            main_inst <= '0;
            main_pc   <= '0;
            skid_inst <= '0;
            skid_pc   <= '0;
        end else begin
            if (ld_main_in) begin
                main_inst <= inst_i;
                main_pc   <= PC_i;
            end else if (ld_main_skid) begin
                main_inst <= skid_inst;
                main_pc   <= skid_pc;
            end else if (to_bubble) begin
                main_inst <= BUBBLE_INST;
            end
            if (ld_skid) begin
                skid_inst <= inst_i;
                skid_pc   <= PC_i;
            end
        end
    end

    // Both counters saturate at all-ones instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: doc/if_id_elastic.md
# if_id_elastic

Parametrised, elastic IF/ID pipeline register with valid/ready handshaking. It holds up to two fetch packets (instruction and PC): one output entry and one skid entry. This lets the fetch stage keep issuing for one cycle after decode back-pressures, with no combinational ready path from decode to fetch. It adds a flush that inserts a configurable bubble, a global start gate, and saturating stall and flush performance counters. It sits between the instruction fetch stage and the decode stage.

## Interface
Parameters:
- INST_W, 32, instruction width
- PC_W, 32, program-counter width
- CNT_W, 16, width of each performance counter
- BUBBLE_INST, 0, value presented on inst_o while the stage is empty or after a flush

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-low
- start_i  input  1  global enable; low freezes all state
- flush_i  input  1  discard all held packets; effective only while start_i=1
- up_valid_i  input  1  fetch offers a packet
- up_ready_o  output  1  stage can accept a packet; reset value 0
- inst_i  input  INST_W  fetched instruction
- PC_i  input  PC_W  PC of the fetched instruction
- dn_valid_o  output  1  output entry holds a valid packet; reset value 0
- dn_ready_i  input  1  decode accepts the output packet
- inst_o  output  INST_W  output instruction; reset value 0
- PC_o  output  PC_W  output PC; reset value 0
- stall_cnt_o  output  CNT_W  cycles with dn_valid_o=1 and dn_ready_i=0; reset value 0
- flush_cnt_o  output  CNT_W  accepted flushes; reset value 0

## Operation
Storage and state:
- Two entries, main (drives the outputs) and skid.
- States: EMPTY (neither valid), ONE (main valid), TWO (main and skid valid).

Handshake signals:
- up_ready_o = start_i & (state != TWO). This is a function of registered state only.
- dn_valid_o = start_i & (state != EMPTY).
- up_fire = up_valid_i & up_ready_o.
- dn_fire = dn_valid_o & dn_ready_i.

Transitions (start_i=1, flush_i=0):
- EMPTY, up_fire: main <= input, go to ONE.
- ONE, up_fire and dn_fire: main <= input, stay in ONE.
- ONE, up_fire only: skid <= input, go to TWO.
- ONE, dn_fire only: go to EMPTY.
- TWO, dn_fire: main <= skid, go to ONE. No input is accepted in TWO.
- Any other combination: hold.

Flush (start_i=1, flush_i=1):
- Highest priority.
- Next state is EMPTY and inst_o becomes BUBBLE_INST.
- A packet offered in the same cycle is dropped, even though up_ready_o may read 1.
- PC_o keeps its last value.
- flush_cnt_o increments.

start_i=0:
- No state, data or counter change.
- flush_i is ignored.
- Both handshake outputs read 0.

Empty stage:
- inst_o = BUBBLE_INST.
- PC_o keeps the last main PC.

Counters:
- Both saturate at 2^CNT_W-1 and never wrap.
- They change only while start_i=1.

Reset:
- Asserting rst_i at any time, including mid-transfer, immediately forces EMPTY, inst_o=0, PC_o=0 and both counters to 0.
- On deassertion the stage resumes at the next rising edge that has start_i=1.

## Timing
- Latency: a packet accepted at edge N appears on inst_o/PC_o with dn_valid_o=1 after edge N. This is 1 cycle when main is free.
- Throughput: 1 packet per cycle when dn_ready_i is held at 1.
- Back-pressure: after dn_ready_i falls, the stage absorbs at most one more packet. up_ready_o falls in the cycle after the skid entry fills.
- No combinational path from dn_ready_i to up_ready_o.
- Flush takes effect at the next edge. Outputs show the bubble and dn_valid_o=0 in the following cycle, and up_ready_o=1 in that same cycle.
- Ordering: packets leave in the order they were accepted. No packet is duplicated or lost except those discarded by a flush.

## Test plan
- Reset: hold rst_i=0 with start_i=1 and random inputs. All outputs must read 0. After release, up_ready_o=1 and dn_valid_o=0.
- Streaming: dn_ready_i=1, feed PC=0x00,0x04,0x08 with inst=0x11,0x22,0x33 on consecutive cycles. The same sequence must appear one cycle later, back-to-back, with dn_valid_o=1.
- Back-pressure: drop dn_ready_i while streaming.
  - The next packet (PC 0x0C) goes to skid and up_ready_o falls.
  - Raise dn_ready_i. The output sequence must be 0x08 then 0x0C, with no loss or duplication.
  - stall_cnt_o must equal the number of held cycles.
- Flush in TWO: fill both entries, then pulse flush_i with up_valid_i=1. The next cycle must show dn_valid_o=0, inst_o=BUBBLE_INST, PC_o unchanged, flush_cnt_o=1 and up_ready_o=1. The packet offered during the flush must never appear.
- Start gating: drop start_i while in TWO and pulse flush_i. State, data and counters must be unchanged, and both handshake outputs must read 0. When start_i rises, draining must resume normally.
- Saturation: with CNT_W=2, hold back-pressure for 6 cycles and issue 5 flushes. Both counters must stop at 3.
